// File: rtl/div_seq_unit_if.sv
// div_seq_unit_if: start/operand/result bundle between the control unit (master) and the divider (slave)
// signals: start, a_in, b_in (to divider); busy, done, div_zero, hi_out, lo_out (from divider)
interface div_seq_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic busy;
  logic done;
  logic div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  modport master (output start, a_in, b_in, input busy, done, div_zero, hi_out, lo_out);
  modport slave (input start, a_in, b_in, output busy, done, div_zero, hi_out, lo_out);
endinterface

// File: rtl/div_seq_unit.sv
// div_seq_unit: iterative signed divider, MIPS DIV semantics (lo_out = quotient, hi_out = remainder)
// ports: clk; reset (synchronous, active-low); bus (slave): start, a_in, b_in in; busy, done, div_zero, hi_out, lo_out out
module div_seq_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic reset,
  div_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] rem, quo, dv;
  logic sa, sb, go, last;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh, diff;
  always_comb begin
    sh = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dv};
    go = state == IDLE && bus.start && |bus.b_in;
    last = cnt == CW'(WIDTH - 1);
    state_n = go ? CALC : (state == CALC && last) ? FIX : state == FIX ? IDLE : state;
  end
  // busy trails the CALC state by one edge so it spans exactly the WIDTH step cycles and drops as done rises
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
      rem <= '0;
      quo <= '0;
      dv <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_n;
      bus.busy <= state == CALC;
      bus.done <= state == FIX;
      bus.div_zero <= state == IDLE && bus.start && ~|bus.b_in;
      if (go) begin
        quo <= bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
        dv <= bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
        sa <= bus.a_in[WIDTH-1];
        sb <= bus.b_in[WIDTH-1];
        rem <= '0;
        cnt <= '0;
      end
      if (state == CALC) begin
        rem <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        bus.lo_out <= (sa ^ sb) ? -quo : quo;
        bus.hi_out <= sa ? -rem : rem;
      end
    end
  end
endmodule
